// File: rtl/i3c_rx_byte_framer.sv
// i3c_rx_byte_framer
// Frames the I3C private-write byte stream from the target bus FSM into transfers.
// Bytes go to the 8-to-N width converter through a small first-word-fall-through
// skid FIFO, because the bus side cannot stall. One RX descriptor is emitted per
// transfer, after every byte of that transfer has been accepted by the converter.
//
// Optional feature: define I3C_RX_DESC_CKSUM_EN to put an XOR checksum of all
// counted bytes in desc_data_o[31:24]. Otherwise that field is 8'h00 and no
// checksum register is built.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   soft_reset_ni      synchronous soft reset, active-low
//   bus_start_i        pulse: private write to this target begins
//   bus_byte_vld_i     pulse: bus_byte_i holds a received byte
//   bus_byte_i         received byte
//   bus_stop_i         pulse: transfer ended (Sr/P)
//   conv_valid_o/ready_i/data_o   byte stream to the converter
//   conv_flush_o       flush the partial converter word
//   desc_valid_o/ready_i/data_o   descriptor: [15:0] count, [16] overflow,
//                      [17] count saturated, [23:18] 0, [31:24] checksum or 0
module i3c_rx_byte_framer #(
  parameter int unsigned Width     = 32,
  parameter int unsigned FifoDepth = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        soft_reset_ni,
  input  logic        bus_start_i,
  input  logic        bus_byte_vld_i,
  input  logic [7:0]  bus_byte_i,
  input  logic        bus_stop_i,
  output logic        conv_valid_o,
  input  logic        conv_ready_i,
  output logic [7:0]  conv_data_o,
  output logic        conv_flush_o,
  output logic        desc_valid_o,
  input  logic        desc_ready_i,
  output logic [31:0] desc_data_o
);

  localparam int unsigned Bytes = Width / 8;
  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_DRAIN,
    S_FLUSH,
    S_DESC
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] fcnt_q, fcnt_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            sat_q, sat_d;
  logic [7:0]      cksum;

  logic fifo_empty, fifo_full, pop, byte_in, push;

  // A pop in the same cycle frees a slot, so a full FIFO still takes the byte.
  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == CntW'(FifoDepth));
  assign pop        = !fifo_empty && conv_ready_i;
  assign byte_in    = (state_q == S_DATA) && bus_byte_vld_i;
  assign push       = byte_in && (!fifo_full || pop);

`ifdef I3C_RX_DESC_CKSUM_EN
  logic [7:0] ck_q, ck_d;
  assign cksum = ck_q;
`else
  assign cksum = 8'h00;
`endif

  // Next-state: transfer FSM, FIFO pointers, byte count and flags
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    sat_d    = sat_q;
`ifdef I3C_RX_DESC_CKSUM_EN
    ck_d     = ck_q;
`endif

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CntW'(1);
      2'b01:   fcnt_d = fcnt_q - CntW'(1);
      default: fcnt_d = fcnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (bus_start_i) begin
          state_d = S_DATA;
          cnt_d   = 16'd0;
          ovf_d   = 1'b0;
          sat_d   = 1'b0;
`ifdef I3C_RX_DESC_CKSUM_EN
          ck_d    = 8'h00;
`endif
        end
      end
      S_DATA: begin
        if (byte_in) begin
          if (push) begin
            if (cnt_q == 16'hFFFF) sat_d = 1'b1;
            else                   cnt_d = cnt_q + 16'd1;
`ifdef I3C_RX_DESC_CKSUM_EN
            ck_d = ck_q ^ bus_byte_i;
`endif
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (bus_stop_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Flush only once the converter has taken every byte, so no handshake overlaps it.
        if (fifo_empty) begin
          if ((cnt_q % 16'(Bytes)) != 16'd0) state_d = S_FLUSH;
          else                               state_d = S_DESC;
        end
      end
      S_FLUSH: state_d = S_DESC;
      S_DESC: begin
        if (desc_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Soft reset discards the transfer in flight, including queued bytes.
    if (!soft_reset_ni) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fcnt_d   = '0;
      cnt_d    = 16'd0;
      ovf_d    = 1'b0;
      sat_d    = 1'b0;
`ifdef I3C_RX_DESC_CKSUM_EN
      ck_d     = 8'h00;
`endif
    end
  end

  // State and control registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      cnt_q    <= 16'd0;
      ovf_q    <= 1'b0;
      sat_q    <= 1'b0;
`ifdef I3C_RX_DESC_CKSUM_EN
      ck_q     <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      sat_q    <= sat_d;
`ifdef I3C_RX_DESC_CKSUM_EN
      ck_q     <= ck_d;
`endif
    end
  end

  // FIFO storage; contents are qualified by fcnt_q so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus_byte_i;
  end

  // Outputs decode registered state only; data is forced to 0 when not valid.
  assign conv_valid_o = !fifo_empty;
  assign conv_data_o  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign conv_flush_o = (state_q == S_FLUSH);
  assign desc_valid_o = (state_q == S_DESC);
  assign desc_data_o  = desc_valid_o ? {cksum, 6'd0, sat_q, ovf_q, cnt_q} : 32'd0;

endmodule

// File: tb/tb_i3c_rx_byte_framer.sv
// Randomized + directed bench for i3c_rx_byte_framer with a queue-based reference model.
module tb_i3c_rx_byte_framer;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BYTES = W / 8;
`ifdef I3C_RX_DESC_CKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        soft_reset_ni = 1'b1;
  logic        bus_start_i = 1'b0;
  logic        bus_byte_vld_i = 1'b0;
  logic [7:0]  bus_byte_i = 8'h00;
  logic        bus_stop_i = 1'b0;
  logic        conv_valid_o;
  logic        conv_ready_i = 1'b0;
  logic [7:0]  conv_data_o;
  logic        conv_flush_o;
  logic        desc_valid_o;
  logic        desc_ready_i = 1'b0;
  logic [31:0] desc_data_o;

  i3c_rx_byte_framer #(.Width(W), .FifoDepth(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .soft_reset_ni  (soft_reset_ni),
    .bus_start_i    (bus_start_i),
    .bus_byte_vld_i (bus_byte_vld_i),
    .bus_byte_i     (bus_byte_i),
    .bus_stop_i     (bus_stop_i),
    .conv_valid_o   (conv_valid_o),
    .conv_ready_i   (conv_ready_i),
    .conv_data_o    (conv_data_o),
    .conv_flush_o   (conv_flush_o),
    .desc_valid_o   (desc_valid_o),
    .desc_ready_i   (desc_ready_i),
    .desc_data_o    (desc_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transfer is open between an accepted start and its stop,
  // and the framer is busy until its descriptor is handed over.
  logic [7:0]  mq[$];
  logic [7:0]  tx_q[$];
  bit          m_busy, m_in_xfer, m_desc_pend, m_flush_pend;
  logic [15:0] m_cnt;
  bit          m_ovf, m_sat;
  logic [7:0]  m_ck;
  logic [31:0] m_desc;
  int          n_beats, n_flush, n_desc;
  logic [31:0] last_desc;
  bit          p_dv, p_dr, p_cv, p_cr;
  logic [31:0] p_dd;
  logic [7:0]  p_cd;

  int rdy_mode  = 1;   // 0 hold low, 1 hold high, 2 random
  int dmode     = 1;

  task automatic model_clear();
    mq.delete();
    m_busy = 0; m_in_xfer = 0; m_desc_pend = 0; m_flush_pend = 0;
    p_dv = 0; p_cv = 0;
  endtask

  // Monitor: on each falling edge compare outputs with the model, then apply
  // the events that the next rising edge will commit.
  initial begin
    bit was_idle, was_in;
    model_clear();
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        check("rst_conv_valid", 32'(conv_valid_o), 32'd0);
        check("rst_conv_data",  32'(conv_data_o),  32'd0);
        check("rst_flush",      32'(conv_flush_o), 32'd0);
        check("rst_desc_valid", 32'(desc_valid_o), 32'd0);
        check("rst_desc_data",  desc_data_o,       32'd0);
        model_clear();
      end else begin
        was_idle = !m_busy;
        was_in   = m_in_xfer;
        check("conv_valid", 32'(conv_valid_o), 32'(mq.size() != 0));
        if (conv_valid_o && mq.size() != 0)
          check("conv_data", 32'(conv_data_o), 32'(mq[0]));
        if (p_cv && !p_cr)
          check("conv_hold", 32'({conv_valid_o, conv_data_o}), 32'({1'b1, p_cd}));
        if (p_dv && !p_dr) begin
          check("desc_hold_valid", 32'(desc_valid_o), 32'd1);
          check("desc_hold_data", desc_data_o, p_dd);
        end
        if (conv_flush_o) begin
          n_flush++;
          check("flush_no_valid", 32'(conv_valid_o), 32'd0);
          check("flush_expected", 32'({m_flush_pend, mq.size() == 0}), 32'd3);
          m_flush_pend = 0;
        end
        if (desc_valid_o) begin
          check("desc_order", 32'({m_desc_pend, m_flush_pend, mq.size() == 0}), 32'd5);
          check("desc_data", desc_data_o, m_desc);
        end

        if (!soft_reset_ni) begin
          model_clear();
        end else begin
          if (conv_valid_o && conv_ready_i && mq.size() != 0) begin
            void'(mq.pop_front());
            n_beats++;
          end
          if (desc_valid_o && desc_ready_i) begin
            n_desc++;
            last_desc   = desc_data_o;
            m_desc_pend = 0;
            m_busy      = 0;
          end
          if (was_in && bus_byte_vld_i) begin
            if (mq.size() < DEPTH) begin
              mq.push_back(bus_byte_i);
              if (m_cnt == 16'hFFFF) m_sat = 1;
              else                   m_cnt = m_cnt + 16'd1;
              m_ck = m_ck ^ bus_byte_i;
            end else begin
              m_ovf = 1;
            end
          end
          if (was_in && bus_stop_i) begin
            m_in_xfer    = 0;
            m_desc_pend  = 1;
            m_flush_pend = (m_cnt % 16'(BYTES)) != 16'd0;
            m_desc       = {(CK_EN ? m_ck : 8'h00), 6'd0, m_sat, m_ovf, m_cnt};
          end
          if (was_idle && bus_start_i) begin
            m_busy = 1; m_in_xfer = 1;
            m_cnt = 16'd0; m_ovf = 0; m_sat = 0; m_ck = 8'h00;
          end
          p_dv = desc_valid_o; p_dr = desc_ready_i; p_dd = desc_data_o;
          p_cv = conv_valid_o; p_cr = conv_ready_i; p_cd = conv_data_o;
        end
      end
    end
  end

  // Ready generators
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      conv_ready_i = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : (rdy_mode == 1);
      desc_ready_i = (dmode == 2) ? 1'($urandom_range(1, 0)) : (dmode == 1);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    bus_start_i = 1'b0;
    bus_byte_vld_i = 1'b0;
    bus_stop_i = 1'b0;
  endtask

  task automatic send_xfer(input int gap_max, input bit noise);
    bus_start_i = 1'b1;
    tick();
    foreach (tx_q[i]) begin
      for (int g = $urandom_range(gap_max, 0); g > 0; g--) begin
        if (noise && $urandom_range(3, 0) == 0) bus_start_i = 1'b1;
        tick();
      end
      bus_byte_vld_i = 1'b1;
      bus_byte_i = tx_q[i];
      tick();
    end
    bus_stop_i = 1'b1;
    if (noise && $urandom_range(1, 0) == 1) begin
      bus_byte_vld_i = 1'b1;
      bus_byte_i = 8'($urandom);
    end
    tick();
    if (noise) begin
      bus_byte_vld_i = 1'b1;
      bus_byte_i = 8'hEE;
      bus_stop_i = 1'b1;
      tick();
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (m_busy && k < budget) begin
      tick();
      k++;
    end
    check("idle_timeout", 32'(m_busy), 32'd0);
  endtask

  task automatic clr_stats();
    n_beats = 0; n_flush = 0; n_desc = 0; last_desc = 32'hDEADBEEF;
  endtask

  initial begin
    clr_stats();
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Five bytes: partial word -> one flush
    clr_stats();
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_xfer(0, 0);
    wait_idle(200);
    check("t1_beats", 32'(n_beats), 32'd5);
    check("t1_flush", 32'(n_flush), 32'd1);
    check("t1_desc", last_desc, {(CK_EN ? 8'h11 : 8'h00), 24'h000005});

    // Eight bytes: whole words, no flush
    clr_stats();
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_xfer(0, 0);
    wait_idle(200);
    check("t2_beats", 32'(n_beats), 32'd8);
    check("t2_flush", 32'(n_flush), 32'd0);
    check("t2_desc", last_desc, {(CK_EN ? 8'h08 : 8'h00), 24'h000008});

    // Back-pressure overflow: 4 kept, 2 dropped
    clr_stats();
    rdy_mode = 0;
    tick();
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_xfer(0, 0);
    rdy_mode = 1;
    wait_idle(200);
    check("t3_beats", 32'(n_beats), 32'd4);
    check("t3_flush", 32'(n_flush), 32'd0);
    check("t3_desc", last_desc, {(CK_EN ? 8'h04 : 8'h00), 24'h010004});

    // Zero-length transfer, descriptor held under back-pressure
    clr_stats();
    dmode = 0;
    tick();
    tx_q.delete();
    send_xfer(0, 0);
    repeat (10) tick();
    check("t4_desc_valid", 32'(desc_valid_o), 32'd1);
    check("t4_desc_data", desc_data_o, 32'd0);
    dmode = 1;
    wait_idle(50);
    check("t4_beats", 32'(n_beats), 32'd0);
    check("t4_flush", 32'(n_flush), 32'd0);
    check("t4_ndesc", 32'(n_desc), 32'd1);

    // Hard reset mid-transfer with three bytes queued
    clr_stats();
    rdy_mode = 0;
    tick();
    bus_start_i = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      bus_byte_vld_i = 1'b1; bus_byte_i = 8'(8'h30 + i); tick();
    end
    check("t5_queued", 32'(conv_valid_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("t5_rst_valid", 32'(conv_valid_o), 32'd0);
    check("t5_rst_desc", 32'(desc_valid_o | conv_flush_o), 32'd0);
    tick(); tick();
    rst_i = 1'b0;
    rdy_mode = 1;
    tick();
    tx_q = '{8'hA5, 8'h0F, 8'hF0};
    send_xfer(0, 0);
    wait_idle(200);
    check("t6_desc", last_desc, {(CK_EN ? 8'h5A : 8'h00), 24'h000003});
    check("t6_beats", 32'(n_beats), 32'd3);

    // Soft reset mid-transfer: nothing emitted
    clr_stats();
    rdy_mode = 0;
    tick();
    bus_start_i = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      bus_byte_vld_i = 1'b1; bus_byte_i = 8'(8'h70 + i); tick();
    end
    soft_reset_ni = 1'b0;
    tick();
    soft_reset_ni = 1'b1;
    rdy_mode = 1;
    repeat (10) tick();
    check("t7_valid", 32'(conv_valid_o), 32'd0);
    check("t7_nothing", 32'(n_desc + n_flush + n_beats), 32'd0);

    // Random transfers with spurious pulses and random ready
    for (int t = 0; t < 40; t++) begin
      rdy_mode = $urandom_range(2, 1);
      dmode    = $urandom_range(2, 1);
      tx_q.delete();
      for (int i = $urandom_range(12, 0); i > 0; i--) tx_q.push_back(8'($urandom));
      send_xfer(2, 1);
      wait_idle(500);
      repeat ($urandom_range(3, 0)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
